conv_line_sequencer: RTL and testbench
======================================

Name: conv_line_sequencer

Overview:
- Sequences the pixel stream into the 3x3 convolution stage by buffering the two previous lines in rotating line RAMs.
- Presents three vertically aligned rows per pixel on the convolution's row input, with matching hcount/vcount/valid.
- Latches the kernel select at frame start so the filter never changes mid-frame.
- Sits between the camera pixel pipeline and the convolution datapath.

Parameters:
HRES, 320, active pixels per line; addresses 0..HRES-1
VRES, 240, active lines per frame
RAM_LATENCY, 2, line RAM read latency in cycles; also the block's pipeline latency
KSEL_W, 3, width of the kernel select field

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
pixel_in  input  16  RGB565 pixel
hcount_in  input  11  pixel column
vcount_in  input  10  pixel row
data_valid_in  input  1  pixel_in/hcount_in/vcount_in valid this cycle
kernel_sel_in  input  KSEL_W  requested kernel, sampled at frame start
data_out  output  3x16  [0]=line v (live), [1]=line v-1, [2]=line v-2, same column
hcount_out  output  11  hcount_in delayed RAM_LATENCY
vcount_out  output  10  vcount_in delayed RAM_LATENCY
data_valid_out  output  1  data_out valid
kernel_sel_out  output  KSEL_W  kernel in force for the current frame

Behaviour:
- Reset (async assert, sync release): state IDLE, rotation index 0, all outputs 0, delay pipelines cleared, row-filled flags cleared.
- Accepted pixel: data_valid_in=1, hcount_in<HRES and vcount_in<VRES. Non-accepted cycles write nothing and produce data_valid_out=0 RAM_LATENCY cycles later.
- Three line RAMs with rotation index r in 0..2.
  - Accepted pixel is written to RAM r at address hcount_in.
  - RAMs (r+2)%3 (line v-1) and (r+1)%3 (line v-2) are read at the same address.
  - Read-before-write is not required because the RAM being written holds line v-3.
- Rotation: accepted pixel with hcount_in==HRES-1 advances r by one (mod 3) after the write.
- States:
  - IDLE: accepted pixels dropped, data_valid_out=0. Leaves to PRIME on an accepted pixel at (0,0).
  - PRIME: vcount_in 0 or 1. Line v-1/v-2 rows not yet written are replaced per Optional Feature. Moves to STREAM on the first accepted pixel of vcount_in==2.
  - STREAM: all three rows from live/RAM data.
- Frame start (accepted pixel at (0,0)) in any state:
  - r reset to 0, filled flags cleared, state to PRIME.
  - kernel_sel_in latched into kernel_sel_out, taking effect the same cycle that pixel's data appears on data_out.
  - This is the only point at which kernel_sel_out changes.
- Latency: exactly RAM_LATENCY cycles from the input cycle to data_out/hcount_out/vcount_out/data_valid_out.
  - Live row and counts pass through a matched delay line, so there are no bubbles and gaps are preserved.
- Reset mid-line: everything discarded; the sequencer waits in IDLE for the next (0,0).

Optional Feature:
- Macro BORDER_REPLICATE_EN.
- Defined: in PRIME, a missing line v-1 row replicates data_out[0]; a missing line v-2 row replicates the line v-1 row.
- Undefined: missing rows output 16'h0000.

Decomposition:
- Shared package conv_pkg holds:
  - typedef rgb565_t (16 bits)
  - typedef row3_t (3 x rgb565_t)
  - constants HRES_DEFAULT=320, VRES_DEFAULT=240
  - enum seq_state_t {IDLE, PRIME, STREAM}
- Sub-module line_ram: single-clock simple dual-port RAM, depth HRES, width 16, parameterised read latency. Instantiated three times.

Test Plan:
- Reset mid-stream → all outputs 0 immediately. Pixels at (5,3) are ignored (data_valid_out stays 0) until the next (0,0).
- Frame of pixel value = {vcount[4:0],hcount[5:0],5'b0} → at out (10,4): data_out[0]/[1]/[2] encode rows 4/3/2, column 10, exactly 2 cycles after input.
- Line 0 with BORDER_REPLICATE_EN undefined → data_out[1]=data_out[2]=0. With the macro defined → both equal data_out[0].
- kernel_sel_in toggles 3→5 at (100,50) → kernel_sel_out stays 3 until the next frame's (0,0), then becomes 5 with that pixel's output.
- Valid gaps (1-of-3 cycles valid) across a line end at hcount 319 → rotation advances once. Output rows stay correct and the valid pattern is reproduced delayed by 2.
- hcount_in=400 with data_valid_in=1 → no RAM write, data_valid_out=0, rotation unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types for the convolution front end: pixel/row types, frame defaults,
// sequencer states and the mod-3 rotation helper for the line RAMs.
package conv_pkg;

    localparam int HRES_DEFAULT = 320;
    localparam int VRES_DEFAULT = 240;

    typedef logic [15:0] rgb565_t;
    typedef rgb565_t [2:0] row3_t;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM
    } seq_state_t;

    function automatic logic [1:0] rot3(input logic [1:0] r, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, r} + {1'b0, k};
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

endpackage

// File: rtl/line_ram.sv
// One buffered video line: simple dual-port RAM with a resettable
// read pipeline of LATENCY stages.
module line_ram #(
    parameter int DEPTH   = 320,
    parameter int WIDTH   = 16,
    parameter int LATENCY = 2,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rpipe [LATENCY];

    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < LATENCY; i++) begin
                rpipe[i] <= '0;
            end
        end else begin
            rpipe[0] <= mem[raddr];
            for (int i = 1; i < LATENCY; i++) begin
                rpipe[i] <= rpipe[i-1];
            end
        end
    end

    assign rdata = rpipe[LATENCY-1];

endmodule

// File: rtl/conv_line_sequencer.sv
// Builds 3 vertically aligned rows per pixel from rotating line RAMs.
// Define BORDER_REPLICATE_EN to replicate rows at the top frame border.
module conv_line_sequencer
    import conv_pkg::*;
#(
    parameter int HRES        = HRES_DEFAULT,
    parameter int VRES        = VRES_DEFAULT,
    parameter int RAM_LATENCY = 2,
    parameter int KSEL_W      = 3
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  rgb565_t           pixel_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              data_valid_in,
    input  logic [KSEL_W-1:0] kernel_sel_in,
    output row3_t             data_out,
    output logic [10:0]       hcount_out,
    output logic [9:0]        vcount_out,
    output logic              data_valid_out,
    output logic [KSEL_W-1:0] kernel_sel_out
);

    localparam int AW = $clog2(HRES);
    localparam int KI = (RAM_LATENCY > 1) ? RAM_LATENCY - 2 : 0;

    typedef struct packed {
        logic              valid;
        logic              fs;
        logic [10:0]       h;
        logic [9:0]        v;
        rgb565_t           px;
        logic [1:0]        r;
        logic              miss1;
        logic              miss2;
        logic [KSEL_W-1:0] ksel;
    } stage_t;

    seq_state_t        state;
    logic [1:0]        r_q;
    logic [2:0]        filled_q;
    logic [KSEL_W-1:0] ksel_q;
    stage_t            pipe [RAM_LATENCY];
    stage_t            cur;
    stage_t            kload;
    stage_t            o;

    logic       accept;
    logic       fs;
    logic       eff;
    logic       last_px;
    logic [1:0] r_eff;
    logic [2:0] base_fill;
    logic [2:0] we;
    logic       use_flags;
    rgb565_t    rd [3];
    rgb565_t    live;
    rgb565_t    l1;
    rgb565_t    l2;

    always_comb begin
        accept    = data_valid_in && (hcount_in < 11'(HRES))
                    && (vcount_in < 10'(VRES));
        fs        = accept && (hcount_in == '0) && (vcount_in == '0);
        eff       = accept && ((state != IDLE) || fs);
        last_px   = eff && (hcount_in == 11'(HRES - 1));
        r_eff     = fs ? 2'd0 : r_q;
        base_fill = fs ? 3'b000 : filled_q;
        we        = eff ? (3'b001 << r_eff) : 3'b000;
        use_flags = fs || (state == PRIME);
        cur       = '0;
        cur.valid = eff;
        cur.fs    = fs;
        cur.h     = hcount_in;
        cur.v     = vcount_in;
        cur.px    = pixel_in;
        cur.r     = r_eff;
        cur.miss1 = use_flags && !base_fill[rot3(r_eff, 2'd2)];
        cur.miss2 = use_flags && !base_fill[rot3(r_eff, 2'd1)];
        cur.ksel  = kernel_sel_in;
        kload     = (RAM_LATENCY == 1) ? cur : pipe[KI];
    end

    for (genvar i = 0; i < 3; i++) begin : g_ram
        line_ram #(
            .DEPTH  (HRES),
            .WIDTH  (16),
            .LATENCY(RAM_LATENCY),
            .AW     (AW)
        ) u_ram (
            .clk_in  (clk_in),
            .rst_n_in(rst_n_in),
            .we      (we[i]),
            .waddr   (hcount_in[AW-1:0]),
            .wdata   (pixel_in),
            .raddr   (hcount_in[AW-1:0]),
            .rdata   (rd[i])
        );
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state    <= IDLE;
            r_q      <= '0;
            filled_q <= '0;
            ksel_q   <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= cur;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
            filled_q <= base_fill | we;
            if (last_px) begin
                r_q <= rot3(r_eff, 2'd1);
            end else if (fs) begin
                r_q <= 2'd0;
            end
            // Kernel switches on the edge that brings the frame-start pixel out
            if (kload.fs) begin
                ksel_q <= kload.ksel;
            end
            unique case (state)
                IDLE: begin
                    if (fs) state <= PRIME;
                end
                PRIME: begin
                    if (fs) state <= PRIME;
                    else if (eff && vcount_in >= 10'd2) state <= STREAM;
                end
                STREAM: begin
                    if (fs) state <= PRIME;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o    = pipe[RAM_LATENCY-1];
        live = o.px;
        l1   = rd[rot3(o.r, 2'd2)];
        l2   = rd[rot3(o.r, 2'd1)];
`ifdef BORDER_REPLICATE_EN
        if (o.miss1) l1 = live;
        if (o.miss2) l2 = l1;
`else
        if (o.miss1) l1 = '0;
        if (o.miss2) l2 = '0;
`endif
        data_out       = o.valid ? {l2, l1, live} : '0;
        hcount_out     = o.h;
        vcount_out     = o.v;
        data_valid_out = o.valid;
        kernel_sel_out = ksel_q;
    end

endmodule

// File: tb/tb_conv_line_sequencer.sv
// Scoreboard bench for conv_line_sequencer: an image-level model predicts
// the three rows of each accepted pixel; a monitor checks every cycle.
module tb_conv_line_sequencer;
    import conv_pkg::*;

    localparam int HRES = 320;
    localparam int VRES = 240;
    localparam int LAT  = 2;
    localparam int KW   = 3;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    rgb565_t       pixel_in = '0;
    logic [10:0]   hcount_in = '0;
    logic [9:0]    vcount_in = '0;
    logic          data_valid_in = 1'b0;
    logic [KW-1:0] kernel_sel_in = '0;
    row3_t         data_out;
    logic [10:0]   hcount_out;
    logic [9:0]    vcount_out;
    logic          data_valid_out;
    logic [KW-1:0] kernel_sel_out;

    conv_line_sequencer #(
        .HRES       (HRES),
        .VRES       (VRES),
        .RAM_LATENCY(LAT),
        .KSEL_W     (KW)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .pixel_in      (pixel_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .data_valid_in (data_valid_in),
        .kernel_sel_in (kernel_sel_in),
        .data_out      (data_out),
        .hcount_out    (hcount_out),
        .vcount_out    (vcount_out),
        .data_valid_out(data_valid_out),
        .kernel_sel_out(kernel_sel_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int            due;
        logic [15:0]   r0;
        logic [15:0]   r1;
        logic [15:0]   r2;
        logic [10:0]   h;
        logic [9:0]    v;
        logic [KW-1:0] k;
    } exp_t;

    exp_t          q[$];
    logic [15:0]   img [int];
    int            cyc = 0;
    int            vectors = 0;
    int            miscompares = 0;
    bit            in_frame = 0;
    logic [KW-1:0] kmodel = '0;
    logic [KW-1:0] ksel_cur = '0;
    int            sw_v = -1;
    int            sw_h = -1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lookup(int v, int h);
        int key;
        key = v * HRES + h;
        return img.exists(key) ? img[key] : 16'h0000;
    endfunction

    // Model: rows come from the image written so far in this frame
    task automatic apply(bit vld, int h, int v, logic [15:0] px);
        exp_t e;
        @(negedge clk_in);
        data_valid_in = vld;
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        pixel_in      = px;
        kernel_sel_in = ksel_cur;
        if (vld && h < HRES && v < VRES) begin
            if (h == 0 && v == 0) begin
                in_frame = 1;
                img.delete();
                kmodel = ksel_cur;
            end
            if (in_frame) begin
                e.due = cyc + LAT;
                e.r0  = px;
`ifdef BORDER_REPLICATE_EN
                e.r1  = (v >= 1) ? lookup(v - 1, h) : px;
                e.r2  = (v >= 2) ? lookup(v - 2, h) : e.r1;
`else
                e.r1  = (v >= 1) ? lookup(v - 1, h) : 16'h0000;
                e.r2  = (v >= 2) ? lookup(v - 2, h) : 16'h0000;
`endif
                e.h   = 11'(h);
                e.v   = 10'(v);
                e.k   = kmodel;
                img[v * HRES + h] = px;
                q.push_back(e);
            end
        end
    endtask

    task automatic idle_cycle(int v, bit glitch);
        if (glitch && $urandom_range(0, 9) == 0)
            apply(1, 400, v, 16'($urandom));
        else
            apply(0, $urandom_range(0, 2047), $urandom_range(0, 1023),
                  16'($urandom));
    endtask

    task automatic drive_line(int v, int ncols, int gap, bit pattern, bit glitch);
        logic [10:0] hh;
        logic [9:0]  vv;
        logic [15:0] px;
        int          idle;
        vv = 10'(v);
        for (int h = 0; h < ncols; h++) begin
            idle = (gap == 0) ? 0 : (gap == 1) ? $urandom_range(0, 2) : 2;
            if (gap == 0 && glitch && $urandom_range(0, 63) == 0) idle = 1;
            for (int i = 0; i < idle; i++) idle_cycle(v, glitch);
            hh = 11'(h);
            px = pattern ? {vv[4:0], hh[5:0], 5'b0} : 16'($urandom);
            if (v == sw_v && h == sw_h) ksel_cur = 3'd5;
            apply(1, h, v, px);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_n_in      = 1'b0;
        data_valid_in = 1'b0;
        q.delete();
        in_frame = 0;
        kmodel   = '0;
        #1;
        chk("rst_valid", 64'(data_valid_out), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_hcount", 64'(hcount_out), 64'd0);
        chk("rst_vcount", 64'(vcount_out), 64'd0);
        chk("rst_kernel", 64'(kernel_sel_out), 64'd0);
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk_in);
            cyc++;
            #1;
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                chk("out_valid", 64'(data_valid_out), 64'd1);
                chk("row0", 64'(data_out[0]), 64'(e.r0));
                chk("row1", 64'(data_out[1]), 64'(e.r1));
                chk("row2", 64'(data_out[2]), 64'(e.r2));
                chk("hcount", 64'(hcount_out), 64'(e.h));
                chk("vcount", 64'(vcount_out), 64'(e.v));
                chk("kernel", 64'(kernel_sel_out), 64'(e.k));
            end else begin
                chk("idle_valid", 64'(data_valid_out), 64'd0);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        do_reset();
        // Pattern frame with random gaps, covers (10,4)
        ksel_cur = 3'd2;
        for (int v = 0; v < 6; v++) drive_line(v, HRES, 1, 1, 0);
        // Random frame interrupted by reset in the middle of a line
        ksel_cur = 3'd6;
        for (int v = 0; v < 3; v++) drive_line(v, HRES, 1, 0, 1);
        drive_line(3, 150, 0, 0, 0);
        do_reset();
        apply(1, 5, 3, 16'($urandom));
        apply(1, 6, 3, 16'($urandom));
        repeat (4) idle_cycle(3, 0);
        // Kernel request changes mid-frame at (100,50)
        ksel_cur = 3'd3;
        sw_v = 50;
        sw_h = 100;
        for (int v = 0; v < 52; v++) drive_line(v, HRES, 0, 0, 1);
        sw_v = -1;
        // Next frame picks up kernel 5; one-in-three valid across line ends
        for (int v = 0; v < 3; v++) drive_line(v, HRES, 2, 0, 0);
        repeat (LAT + 3) idle_cycle(0, 0);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
